// File: rtl/sme_param.sv
// Small string-matching engine: loads a string and a pattern with '.', '^' and '$',
// then scans one candidate start position per cycle and reports first/last match and count.
module sme_param #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8,
    localparam int IDX_W = $clog2(STR_MAX),
    localparam int CNT_W = $clog2(STR_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       chardata,
    input  logic             isstring,
    input  logic             ispattern,
    input  logic             last_mode,
    output logic             valid,
    output logic             match,
    output logic [IDX_W-1:0] match_index,
    output logic [CNT_W-1:0] match_count
);
    localparam int PI_W = $clog2(PAT_MAX);
    localparam int PL_W = $clog2(PAT_MAX + 1);
    localparam logic [7:0] CH_ANY = 8'h2E;
    localparam logic [7:0] CH_BOL = 8'h5E;
    localparam logic [7:0] CH_EOL = 8'h24;
    localparam logic [7:0] CH_SP  = 8'h20;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_STR = 3'd1,
        LOAD_PAT = 3'd2,
        SEARCH   = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t           state;
    logic [7:0]       str_mem [STR_MAX];
    logic [7:0]       pat_mem [PAT_MAX];
    logic [CNT_W-1:0] str_len;
    logic [PL_W-1:0]  pat_len;
    logic [CNT_W-1:0] cand;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] best;
    logic             found;
    logic             last_sel;

    logic               anc_bol;
    logic               anc_eol;
    logic               no_cand;
    logic               is_last;
    logic               bol_ok;
    logic               eol_ok;
    logic               hit;
    logic               found_nx;
    logic [PAT_MAX-1:0] lit_ok;
    logic [CNT_W-1:0]   cnt_nx;
    logic [IDX_W-1:0]   best_nx;
    int                 lit_len;
    int                 lit_off;
    int                 last_p;
    int                 end_pos;

    // Pattern decode: '^'/'$' are anchors only at the pattern ends, literal elsewhere
    always_comb begin
        anc_bol = (pat_len != {PL_W{1'b0}}) && (pat_mem[{PI_W{1'b0}}] == CH_BOL);
        anc_eol = (pat_len != {PL_W{1'b0}}) && (pat_mem[PI_W'(int'(pat_len) - 32'sd1)] == CH_EOL);
        lit_off = int'(anc_bol);
        lit_len = int'(pat_len) - int'(anc_bol) - int'(anc_eol);
        last_p  = int'(str_len) - lit_len;
        no_cand = (lit_len == 32'sd0) || (lit_len > int'(str_len));
        is_last = no_cand || (int'(cand) >= last_p);
        end_pos = int'(cand) + lit_len;
    end

    // Candidate test: every literal position compared in parallel, plus both anchors
    always_comb begin
        lit_ok = {PAT_MAX{1'b1}};
        for (int i = 0; i < PAT_MAX; i++) begin
            lit_ok[i] = (i >= lit_len)
                     || (pat_mem[PI_W'(i + lit_off)] == CH_ANY)
                     || (pat_mem[PI_W'(i + lit_off)] == str_mem[IDX_W'(int'(cand) + i)]);
        end
        bol_ok = !anc_bol || (cand == {CNT_W{1'b0}})
              || (str_mem[IDX_W'(int'(cand) - 32'sd1)] == CH_SP);
        eol_ok = !anc_eol || (end_pos == int'(str_len))
              || (str_mem[IDX_W'(end_pos)] == CH_SP);
        hit = !no_cand && (&lit_ok) && bol_ok && eol_ok;
    end

    // Running result including the candidate evaluated this cycle
    always_comb begin
        cnt_nx   = cnt + {{(CNT_W-1){1'b0}}, hit};
        found_nx = found | hit;
        if (hit && (last_sel || !found)) begin
            best_nx = IDX_W'(cand);
        end else begin
            best_nx = best;
        end
    end

    // Control FSM, load buffers and registered result
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            str_len     <= {CNT_W{1'b0}};
            pat_len     <= {PL_W{1'b0}};
            cand        <= {CNT_W{1'b0}};
            cnt         <= {CNT_W{1'b0}};
            best        <= {IDX_W{1'b0}};
            found       <= 1'b0;
            last_sel    <= 1'b0;
            valid       <= 1'b0;
            match       <= 1'b0;
            match_index <= {IDX_W{1'b0}};
            match_count <= {CNT_W{1'b0}};
        end else begin
            valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (isstring) begin
                        str_mem[{IDX_W{1'b0}}] <= chardata;
                        str_len                <= CNT_W'(1'b1);
                        state                  <= LOAD_STR;
                    end else if (ispattern) begin
                        pat_mem[{PI_W{1'b0}}] <= chardata;
                        pat_len               <= PL_W'(1'b1);
                        state                 <= LOAD_PAT;
                    end
                end
                LOAD_STR: begin
                    if (isstring) begin
                        if (int'(str_len) < STR_MAX) begin
                            str_mem[IDX_W'(str_len)] <= chardata;
                            str_len                  <= str_len + CNT_W'(1'b1);
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD_PAT: begin
                    if (ispattern) begin
                        if (int'(pat_len) < PAT_MAX) begin
                            pat_mem[PI_W'(pat_len)] <= chardata;
                            pat_len                 <= pat_len + PL_W'(1'b1);
                        end
                    end else begin
                        state    <= SEARCH;
                        cand     <= {CNT_W{1'b0}};
                        cnt      <= {CNT_W{1'b0}};
                        best     <= {IDX_W{1'b0}};
                        found    <= 1'b0;
                        last_sel <= last_mode;
                    end
                end
                SEARCH: begin
                    cnt   <= cnt_nx;
                    found <= found_nx;
                    best  <= best_nx;
                    cand  <= cand + CNT_W'(1'b1);
                    if (is_last) begin
                        state       <= DONE;
                        valid       <= 1'b1;
                        match       <= found_nx;
                        match_index <= found_nx ? best_nx : {IDX_W{1'b0}};
                        match_count <= cnt_nx;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sme_param.sv
// Bench for sme_param: directed vector table, random runs against a string-level model,
// and a reset-during-search sequence.
module tb_sme_param;
    localparam int STR_MAX = 32;
    localparam int PAT_MAX = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       last_mode;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
    logic [5:0] match_count;

    int    total = 0;
    int    bad   = 0;
    string cur_str = "";

    typedef struct {
        string s;
        string p;
        bit    lm;
        bit    em;
        int    ei;
        int    ec;
    } vec_t;

    vec_t vecs[10];

    sme_param #(.STR_MAX(STR_MAX), .PAT_MAX(PAT_MAX)) dut (
        .clk         (clk),
        .reset       (reset),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .last_mode   (last_mode),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string nm, input logic [31:0] act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference: truncate both inputs, strip anchors, scan every start position.
    function automatic void model(input string s_in, input string p_in, input bit lm,
                                  output bit m, output int idx, output int cnt, output int lat);
        string s;
        string p;
        int    ls, lp, lc, off, e;
        bit    a0, a1, ok;
        s = s_in;
        if (s.len() > STR_MAX) s = s.substr(0, STR_MAX - 1);
        p = p_in;
        if (p.len() > PAT_MAX) p = p.substr(0, PAT_MAX - 1);
        ls  = s.len();
        lp  = p.len();
        a0  = (lp > 0) && (p[0] == 8'h5E);
        a1  = (lp > 0) && (p[lp-1] == 8'h24);
        lc  = lp - int'(a0) - int'(a1);
        off = int'(a0);
        m = 1'b0; idx = 0; cnt = 0;
        if (lc == 0 || lc > ls) begin
            lat = 2;
        end else begin
            lat = ls - lc + 2;
            for (int pos = 0; pos <= ls - lc; pos++) begin
                ok = 1'b1;
                for (int k = 0; k < lc; k++)
                    if (p[off+k] != 8'h2E && p[off+k] != s[pos+k]) ok = 1'b0;
                if (a0 && pos != 0 && s[pos-1] != 8'h20) ok = 1'b0;
                e = pos + lc;
                if (a1 && e != ls && s[e] != 8'h20) ok = 1'b0;
                if (ok) begin
                    cnt++;
                    if (!m || lm) idx = pos;
                    m = 1'b1;
                end
            end
        end
    endfunction

    task automatic drive_str(input string s);
        for (int i = 0; i < s.len(); i++) begin
            isstring = 1'b1;
            chardata = s[i];
            @(posedge clk); #1;
        end
        isstring = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic run(input string nm, input string s, input string p, input bit lm,
                       input bit em, input int ei, input int ec);
        bit m_mod;
        int i_mod, c_mod, lat;
        int k;
        bit seen;
        if (s.len() > 0) begin
            drive_str(s);
            cur_str = s;
        end
        model(cur_str, p, lm, m_mod, i_mod, c_mod, lat);
        last_mode = lm;
        for (int i = 0; i < p.len(); i++) begin
            ispattern = 1'b1;
            chardata  = p[i];
            @(posedge clk); #1;
        end
        ispattern = 1'b0;
        seen = 1'b0;
        k = 0;
        while (!seen && k < 100) begin
            @(posedge clk); #1;
            k++;
            if (valid === 1'b1) seen = 1'b1;
        end
        check($sformatf("%s.latency", nm), seen ? k : -1, lat);
        check($sformatf("%s.match", nm), match, int'(em));
        check($sformatf("%s.index", nm), match_index, ei);
        check($sformatf("%s.count", nm), match_count, ec);
        @(posedge clk); #1;
        check($sformatf("%s.single_strobe", nm), valid, 0);
        check($sformatf("%s.hold_count", nm), match_count, ec);
    endtask

    initial begin
        string s, p, alph_s, alph_p;
        bit    m_mod;
        int    i_mod, c_mod, lat, nvalid;

        vecs[0] = '{"hello world", "wor", 1'b0, 1'b1, 6, 1};
        vecs[1] = '{"", "^w.r", 1'b0, 1'b1, 6, 1};
        vecs[2] = '{"", "o$", 1'b0, 1'b1, 4, 1};
        vecs[3] = '{"abab ab", "ab", 1'b0, 1'b1, 0, 3};
        vecs[4] = '{"", "ab", 1'b1, 1'b1, 5, 3};
        vecs[5] = '{"abc", "abcd", 1'b0, 1'b0, 0, 0};
        vecs[6] = '{"ABCDEFGHIJKLMNOPQRSTUVWXYZabcdefghijklmn", "lmn", 1'b0, 1'b0, 0, 0};
        vecs[7] = '{"hello world", "^hello world$", 1'b0, 1'b1, 0, 1};
        vecs[8] = '{"a.b", ".", 1'b1, 1'b1, 2, 3};
        vecs[9] = '{"", "^$", 1'b0, 1'b0, 0, 0};

        reset = 1'b1; isstring = 1'b0; ispattern = 1'b0; last_mode = 1'b0; chardata = 8'h00;
        @(posedge clk); @(posedge clk); #1;
        check("reset.valid", valid, 0);
        check("reset.match", match, 0);
        check("reset.index", match_index, 0);
        check("reset.count", match_count, 0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int v = 0; v < 10; v++)
            run($sformatf("vec%0d", v), vecs[v].s, vecs[v].p, vecs[v].lm,
                vecs[v].em, vecs[v].ei, vecs[v].ec);

        // Random runs; an empty string reuses the stored one
        alph_s = "ab .";
        alph_p = "ab.^$ ";
        for (int r = 0; r < 30; r++) begin
            s = "";
            if ($urandom_range(3, 0) != 0) begin
                for (int i = 0; i < int'($urandom_range(40, 1)); i++)
                    s = $sformatf("%s%c", s, alph_s[$urandom_range(3, 0)]);
            end
            p = "";
            for (int i = 0; i < int'($urandom_range(10, 1)); i++)
                p = $sformatf("%s%c", p, alph_p[$urandom_range(5, 0)]);
            model((s.len() > 0) ? s : cur_str, p, r[0], m_mod, i_mod, c_mod, lat);
            run($sformatf("rnd%0d", r), s, p, r[0], m_mod, i_mod, c_mod);
        end

        // Reset in the middle of a long search must abort without a result
        s = "";
        for (int i = 0; i < 32; i++) s = $sformatf("%sa", s);
        drive_str(s);
        last_mode = 1'b0;
        ispattern = 1'b1; chardata = 8'h61;
        @(posedge clk); #1;
        ispattern = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        cur_str = "";
        check("abort.valid", valid, 0);
        check("abort.match", match, 0);
        check("abort.index", match_index, 0);
        check("abort.count", match_count, 0);
        nvalid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (valid !== 1'b0) nvalid++;
        end
        check("abort.no_valid", nvalid, 0);
        check("abort.count_after", match_count, 0);
        run("post_reset", "xyz", "y", 1'b0, 1'b1, 1, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sme_param.md
SME_PARAM -- requirements
Module: sme_param

Interface
REQ-001 SHALL provide parameter STR_MAX, default 32: maximum stored string length in characters.
REQ-002 SHALL provide parameter PAT_MAX, default 8: maximum stored pattern length in characters, anchors included.
REQ-003 SHALL derive IDX_W = clog2(STR_MAX) and CNT_W = clog2(STR_MAX+1).
REQ-004 SHALL have port clk, input, 1: clock; all state changes on the rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port chardata, input, 8: ASCII character, sampled when isstring or ispattern is 1.
REQ-007 SHALL have port isstring, input, 1: chardata is the next string character.
REQ-008 SHALL have port ispattern, input, 1: chardata is the next pattern character.
REQ-009 SHALL have port last_mode, input, 1: 0 reports the first match, 1 reports the last match; sampled on SEARCH entry.
REQ-010 SHALL have port valid, output, 1: one-cycle result strobe.
REQ-011 SHALL have port match, output, 1: at least one match exists.
REQ-012 SHALL have port match_index, output, IDX_W: start position of the reported match.
REQ-013 SHALL have port match_count, output, CNT_W: number of matching start positions.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD_STR, LOAD_PAT, SEARCH, DONE.
REQ-015 SHALL, on a first isstring=1 cycle from IDLE, clear the string length and store chardata at index 0, then enter LOAD_STR; each further isstring cycle appends.
REQ-016 SHALL store at most STR_MAX string characters; the length saturates at STR_MAX and excess characters are discarded.
REQ-017 SHALL, on a first ispattern=1 cycle from IDLE, clear the pattern and enter LOAD_PAT, holding at most PAT_MAX characters on the same saturate/discard rule.
REQ-018 SHALL retain the stored string across patterns, so successive patterns search the same string until a new isstring burst arrives.
REQ-019 SHALL enter SEARCH on the first cycle in LOAD_PAT with ispattern=0, and SHALL return LOAD_STR to IDLE when isstring=0.
REQ-020 SHALL ignore isstring/ispattern while in SEARCH or DONE.
REQ-021 SHALL treat '.' (0x2E) as matching any single character.
REQ-022 SHALL treat '^' (0x5E) only as the first pattern character: a zero-width anchor satisfied at position p when p==0 or string[p-1]==0x20; elsewhere it is a literal.
REQ-023 SHALL treat '$' (0x24) only as the last pattern character: a zero-width anchor satisfied at end position e when e==len or string[e]==0x20; elsewhere it is a literal.
REQ-024 SHALL define Lc as the pattern length excluding anchors, and candidate starts as p = 0..len-Lc.
REQ-025 SHALL evaluate one candidate per cycle, comparing all Lc positions in parallel; SEARCH lasts max(len-Lc+1, 1) cycles.
REQ-026 SHALL increment match_count per matching candidate; first mode records the lowest matching p, last mode the highest.
REQ-027 SHALL report no match (match=0, match_index=0, match_count=0) when Lc==0 or Lc>len, after exactly one SEARCH cycle.
REQ-028 SHALL enter DONE after the final candidate, assert valid for exactly that one cycle, then return to IDLE.
REQ-029 SHALL update match/match_index/match_count only at valid and hold them until the next valid; match_index is 0 when match=0.
REQ-030 SHALL accept a new isstring/ispattern burst on the cycle after DONE.

Reset
REQ-031 SHALL, on reset=1, go to IDLE, clear string and pattern lengths, and drive valid=0, match=0, match_index=0, match_count=0 on the next edge.
REQ-032 SHALL abort any load or search on reset and never assert valid for the aborted operation.

Verification
REQ-033 SHALL cover: string "hello world", pattern "wor", last_mode=0 -> valid once, match=1, index=6, count=1.
REQ-034 SHALL cover: same string, pattern "^w.r" -> 1/6/1; pattern "o$" -> 1/4/1 (space anchor).
REQ-035 SHALL cover: string "abab ab", pattern "ab" -> last_mode=0 gives 1/0/3; last_mode=1 gives 1/5/3.
REQ-036 SHALL cover: string "abc", pattern "abcd" -> match=0/0/0, valid exactly 2 cycles after ispattern falls.
REQ-037 SHALL cover: 40-character string with pattern equal to characters 37..39 -> match=0, count=0 (truncation).
REQ-038 SHALL cover: reset asserted mid-SEARCH -> no valid, all outputs 0; a following "xyz"/"y" run -> 1/1/1.
